// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, token-to-control mapping and decoder states
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'h354;
    localparam logic [9:0] TOKEN_C01 = 10'h0AB;
    localparam logic [9:0] TOKEN_C10 = 10'h154;
    localparam logic [9:0] TOKEN_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [1:0] token_to_c(input logic [9:0] q);
        logic [1:0] r;
        case (q)
            TOKEN_C01: r = 2'b01;
            TOKEN_C10: r = 2'b10;
            TOKEN_C11: r = 2'b11;
            default:   r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational decode of one aligned 10-bit TMDS symbol
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic       is_token,
    output logic [1:0] c,
    output logic [7:0] data,
    output logic       invalid
);

    logic [7:0] d;
    logic [3:0] ones;
    logic       use_xnor;

    always_comb begin
        is_token = (q == TOKEN_C00) || (q == TOKEN_C01) ||
                   (q == TOKEN_C10) || (q == TOKEN_C11);
        c        = token_to_c(q);
        d        = q[9] ? ~q[7:0] : q[7:0];
        data     = '0;
        data[0]  = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, data[i]};
        end
        // Re-run the encoder's XOR/XNOR choice on the recovered byte; q[8] must agree.
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
        invalid  = !is_token && (q[8] != !use_xnor);
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel symbol aligner and decoder for one HDMI/DVI lane
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int ERR_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raw,
    output logic [7:0] data,
    output logic [1:0] c,
    output logic       blank,
    output logic       locked,
    output logic [3:0] offset,
    output logic       code_err
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    logic [9:0]    raw_q, raw_q1;
    logic [19:0]   window;
    logic [9:0]    q;
    logic          is_token, invalid;
    logic [1:0]    sym_c;
    logic [7:0]    sym_data;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [EW-1:0] err_cnt, err_cnt_d;
    logic [3:0]    offset_d, offset_adv;
    logic [7:0]    data_d;
    logic [1:0]    c_d;
    logic          blank_d, code_err_d;

    assign window     = {raw_q, raw_q1};
    assign q          = 10'(window >> offset);
    assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    tmds_symbol_decode u_decode (
        .q        (q),
        .is_token (is_token),
        .c        (sym_c),
        .data     (sym_data),
        .invalid  (invalid)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        err_cnt_d = err_cnt;
        offset_d  = offset;
        case (state)
            SEARCH: begin
                if (is_token) begin
                    cnt_d     = CW'(1);
                    err_cnt_d = '0;
                    state_d   = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
                end else begin
                    cnt_d    = '0;
                    offset_d = offset_adv;
                end
            end
            VERIFY: begin
                if (is_token) begin
                    cnt_d = cnt + CW'(1);
                    if (cnt_d >= CW'(LOCK_COUNT)) begin
                        state_d   = LOCKED;
                        err_cnt_d = '0;
                    end
                end else begin
                    state_d  = SEARCH;
                    cnt_d    = '0;
                    offset_d = offset_adv;
                end
            end
            LOCKED: begin
                if (is_token) begin
                    err_cnt_d = '0;
                end else if (invalid) begin
                    err_cnt_d = err_cnt + EW'(1);
                    if (err_cnt_d >= EW'(ERR_LIMIT)) begin
                        state_d  = SEARCH;
                        cnt_d    = '0;
                        offset_d = offset_adv;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Outputs follow the state being entered, so locked and the first decoded
    // symbol appear together, and the drop edge already shows unlocked values.
    always_comb begin
        data_d     = '0;
        c_d        = c;
        blank_d    = 1'b1;
        code_err_d = 1'b0;
        if (state_d == LOCKED) begin
            if (is_token) begin
                c_d = sym_c;
            end else begin
                data_d     = sym_data;
                blank_d    = 1'b0;
                code_err_d = invalid;
            end
        end else begin
            c_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q    <= '0;
            raw_q1   <= '0;
            state    <= SEARCH;
            cnt      <= '0;
            err_cnt  <= '0;
            offset   <= '0;
            data     <= '0;
            c        <= 2'b00;
            blank    <= 1'b1;
            locked   <= 1'b0;
            code_err <= 1'b0;
        end else begin
            raw_q    <= raw;
            raw_q1   <= raw_q;
            state    <= state_d;
            cnt      <= cnt_d;
            err_cnt  <= err_cnt_d;
            offset   <= offset_d;
            data     <= data_d;
            c        <= c_d;
            blank    <= blank_d;
            locked   <= (state_d == LOCKED);
            code_err <= code_err_d;
        end
    end

endmodule
